// File: rtl/joy_pkg.sv
// joy_pkg: state encoding and button bit positions shared by the DB15 reader and the device-side emulator
package joy_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam int J_R  = 0;
    localparam int J_L  = 1;
    localparam int J_D  = 2;
    localparam int J_U  = 3;
    localparam int J_B1 = 4;
    localparam int J_B2 = 5;
    localparam int J_B3 = 6;
    localparam int J_B4 = 7;
    localparam int J_B5 = 8;
    localparam int J_B6 = 9;
    localparam int J_B7 = 10;
    localparam int J_B8 = 11;
endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: brings an asynchronous strobe into clk, rejects pulses shorter than FILT samples, flags edges
module strobe_sync #(
    parameter int   FILT = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic       s1_q, s2_q, lvl_q, lvl_d, prev_q;
    logic [3:0] cnt_q, cnt_d;

    if (FILT < 1 || FILT > 15) begin : g_filt_chk
        $error("FILT must be in 1..15");
    end

    // count consecutive samples that disagree with the accepted level; any agreement restarts the count
    always_comb begin
        cnt_d = (s2_q == lvl_q) ? 4'd0 : cnt_q + 4'd1;
        lvl_d = (cnt_d == 4'(FILT)) ? s2_q : lvl_q;
    end

    // two-flop synchroniser, filter state and previous filtered level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= INIT;
            s2_q   <= INIT;
            lvl_q  <= INIT;
            prev_q <= INIT;
            cnt_q  <= 4'd0;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = lvl_q & ~prev_q;
    assign fall = ~lvl_q & prev_q;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device side of the DB15 link, a 74HC165-style parallel-in/serial-out chain for two players
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int W      = 12,
    parameter int FILT   = 2,
    parameter int INVERT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] joy1_in,
    input  logic [W-1:0] joy2_in,
    input  logic         joy_load,
    input  logic         joy_clk,
    output logic         joy_data,
    output logic         frame_done,
    output logic [5:0]   bit_cnt
);
    localparam int         N    = 2 * W;
    localparam logic [5:0] NCNT = 6'(N);
    localparam logic       FILL = (INVERT == 0);

    if (N > 63) begin : g_len_chk
        $error("2*W must not exceed 63");
    end

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           load_lvl, load_rise, load_fall, clk_rise;
    logic           unused_clk_lvl, unused_clk_fall;

    strobe_sync #(.FILT(FILT), .INIT(1'b1)) u_load (
        .clk(clk), .reset(reset), .d_in(joy_load),
        .lvl(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    strobe_sync #(.FILT(FILT), .INIT(1'b0)) u_clk (
        .clk(clk), .reset(reset), .d_in(joy_clk),
        .lvl(unused_clk_lvl), .rise(clk_rise), .fall(unused_clk_fall)
    );

    // next-state: a low load level always wins over a shift edge, so a coincident edge pair reloads
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sr_d    = {N{FILL}};
                state_d = load_fall ? LOAD : IDLE;
            end
            LOAD: begin
                sr_d    = {joy2_in, joy1_in};
                cnt_d   = 6'd0;
                state_d = load_rise ? SHIFT : LOAD;
            end
            default: begin
                if (!load_lvl) begin
                    state_d = LOAD;
                    sr_d    = {joy2_in, joy1_in};
                    cnt_d   = 6'd0;
                end else if (clk_rise) begin
                    sr_d = {FILL, sr_q[N-1:1]};
                    if (state_q == SHIFT) begin
                        cnt_d   = cnt_q + 6'd1;
                        done_d  = (cnt_d == NCNT);
                        state_d = done_d ? DONE : SHIFT;
                    end
                end
            end
        endcase
    end

    // FSM, shift chain and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= {N{FILL}};
            cnt_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign joy_data   = (INVERT != 0) ? ~sr_q[0] : sr_q[0];
    assign frame_done = done_q;
    assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed and randomised frames checked against a bit-list model of the DB15 chain
module tb_joy_db15_tx;
    localparam int W = 12;
    localparam int N = 2 * W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] joy1_in = '0;
    logic [W-1:0] joy2_in = '0;
    logic         joy_load = 1'b1;
    logic         joy_clk = 1'b0;
    logic         joy_data, frame_done;
    logic [5:0]   bit_cnt;
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic [N-1:0] word = '0;

    joy_db15_tx #(.W(W), .FILT(2), .INVERT(1)) dut (
        .clk(clk), .reset(reset), .joy1_in(joy1_in), .joy2_in(joy2_in),
        .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data),
        .frame_done(frame_done), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // line level the reader should see for chain position k: pressed drives low, past the end reads idle
    function automatic logic exp_bit(input logic [N-1:0] w, input int k);
        return (k >= N) ? 1'b1 : ~w[k];
    endfunction

    task automatic pulse_clk(input int hi);
        joy_clk = 1'b1;
        tick(hi);
        joy_clk = 1'b0;
        tick(10);
    endtask

    task automatic load_word(input logic [W-1:0] j1, input logic [W-1:0] j2);
        joy1_in = j1;
        joy2_in = j2;
        joy_load = 1'b0;
        tick(10);
        check("load_cnt", {26'd0, bit_cnt}, 0);
        check("load_data", {31'd0, joy_data}, {31'd0, ~j1[0]});
        joy_load = 1'b1;
        tick(10);
        word = {j2, j1};
    endtask

    task automatic shift_bits(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            check($sformatf("bit%0d", i), {31'd0, joy_data}, {31'd0, exp_bit(word, i)});
            pulse_clk(10);
        end
    endtask

    task automatic run_frame(input logic [W-1:0] j1, input logic [W-1:0] j2, input int n);
        int d0;
        load_word(j1, j2);
        d0 = done_cnt;
        shift_bits(0, n);
        check("frame_cnt", {26'd0, bit_cnt}, (n < N) ? n : N);
        check("frame_done", done_cnt - d0, (n >= N) ? 1 : 0);
    endtask

    initial begin
        int d0;
        logic [5:0] c0;
        logic       q0;
        tick(3);
        check("rst_data", {31'd0, joy_data}, 1);
        check("rst_cnt", {26'd0, bit_cnt}, 0);
        check("rst_done", {31'd0, frame_done}, 0);
        reset = 1'b0;
        tick(100);
        check("idle_data", {31'd0, joy_data}, 1);
        check("idle_cnt", {26'd0, bit_cnt}, 0);
        check("idle_done", done_cnt, 0);

        run_frame(12'h005, 12'h800, N);
        d0 = done_cnt;
        shift_bits(N, 5);
        check("extra_cnt", {26'd0, bit_cnt}, N);
        check("extra_done", done_cnt - d0, 0);

        load_word(12'h5a3, 12'h0f1);
        d0 = done_cnt;
        shift_bits(0, 7);
        joy1_in = 12'h001;
        joy_load = 1'b0;
        tick(6);
        check("abort_cnt", {26'd0, bit_cnt}, 0);
        check("abort_data", {31'd0, joy_data}, 0);
        check("abort_done", done_cnt - d0, 0);
        tick(4);
        joy_load = 1'b1;
        tick(10);
        word = {joy2_in, 12'h001};
        d0 = done_cnt;
        shift_bits(0, N);
        check("reload_cnt", {26'd0, bit_cnt}, N);
        check("reload_done", done_cnt - d0, 1);

        load_word(12'h3c6, 12'h9e4);
        shift_bits(0, 5);
        c0 = bit_cnt;
        q0 = joy_data;
        joy_clk = 1'b1;
        tick(1);
        joy_clk = 1'b0;
        tick(10);
        check("gclk_cnt", {26'd0, bit_cnt}, {26'd0, c0});
        check("gclk_data", {31'd0, joy_data}, {31'd0, q0});
        joy_load = 1'b0;
        tick(1);
        joy_load = 1'b1;
        tick(10);
        check("gload_cnt", {26'd0, bit_cnt}, {26'd0, c0});
        check("gload_data", {31'd0, joy_data}, {31'd0, q0});
        pulse_clk(3);
        check("clk3_cnt", {26'd0, bit_cnt}, {26'd0, c0} + 1);
        check("clk3_data", {31'd0, joy_data}, {31'd0, exp_bit(word, 6)});
        joy_load = 1'b0;
        tick(3);
        joy_load = 1'b1;
        tick(10);
        check("load3_cnt", {26'd0, bit_cnt}, 0);
        check("load3_data", {31'd0, joy_data}, {31'd0, exp_bit(word, 0)});

        shift_bits(0, 4);
        joy1_in = 12'h7fe;
        joy_clk = 1'b1;
        joy_load = 1'b0;
        tick(10);
        check("simul_cnt", {26'd0, bit_cnt}, 0);
        check("simul_data", {31'd0, joy_data}, 1);
        joy_clk = 1'b0;
        tick(10);
        check("simul_hold", {26'd0, bit_cnt}, 0);
        joy_load = 1'b1;
        tick(10);
        word = {joy2_in, joy1_in};
        shift_bits(0, 9);
        reset = 1'b1;
        #1;
        check("amid_data", {31'd0, joy_data}, 1);
        check("amid_cnt", {26'd0, bit_cnt}, 0);
        check("amid_done", {31'd0, frame_done}, 0);
        tick(3);
        reset = 1'b0;
        tick(10);

        for (int f = 0; f < 4; f++) begin
            run_frame(W'($urandom), W'($urandom), (f == 0) ? N : int'($urandom_range(1, 30)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
